poly_eval: RTL and testbench



---
 rtl/poly_eval_pkg.sv | 30 +++
 rtl/poly_eval_datapath.sv | 105 ++++++++++
 rtl/poly_eval.sv | 132 +++++++++++++
 tb/tb_poly_eval.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/poly_eval_pkg.sv
// Shared types and constants for the quadratic evaluator.
package poly_eval_pkg;

    localparam int W_DEF  = 16;
    localparam int XW_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL1 = 3'd2,
        S_ADD1 = 3'd3,
        S_MUL2 = 3'd4,
        S_ADD2 = 3'd5,
        S_DONE = 3'd6
    } state_e;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_MUL = 1'b1;

    localparam logic [1:0] M0_A   = 2'd0;
    localparam logic [1:0] M0_ALU = 2'd1;

    localparam logic [1:0] M1_X = 2'd0;
    localparam logic [1:0] M1_B = 2'd1;
    localparam logic [1:0] M1_C = 2'd2;

    localparam logic [1:0] M2_HOLD = 2'd0;
    localparam logic [1:0] M2_ALU  = 2'd1;

endpackage

// File: rtl/poly_eval_datapath.sv
// Operand datapath: RX, RS (accumulator), RH (result), shared add/mul ALU,
// operand muxes and the sticky overflow flag.
module poly_eval_datapath
    import poly_eval_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int XW = XW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          lx_i,
    input  logic          ls_i,
    input  logic          lh_i,
    input  logic          sel_ula_i,
    input  logic [1:0]    m0_i,
    input  logic [1:0]    m1_i,
    input  logic [1:0]    m2_i,
    input  logic [XW-1:0] x_i,
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    input  logic [W-1:0]  c_i,
    output logic [W-1:0]  rh_o,
    output logic          ovf_o
);

    logic [XW-1:0]  rx_q, rx_d;
    logic [W-1:0]   rs_q, rs_d;
    logic [W-1:0]   rh_q, rh_d;
    logic           ovf_q, ovf_d;

    logic [W-1:0]   opnd_b;
    logic [2*W-1:0] prod_w;
    logic [W:0]     sum_w;
    logic [W-1:0]   alu_res;
    logic           alu_ovf;

    // Second ALU operand: zero-extended X register, or live B / C inputs.
    always_comb begin
        opnd_b = W'(rx_q);
        case (m1_i)
            M1_B:    opnd_b = b_i;
            M1_C:    opnd_b = c_i;
            default: opnd_b = W'(rx_q);
        endcase
    end

    // Full-width product and sum so that any lost bits can be flagged.
    assign prod_w = (2*W)'(rs_q) * (2*W)'(opnd_b);
    assign sum_w  = (W+1)'(rs_q) + (W+1)'(opnd_b);

    // ALU result select and the matching loss-of-bits indication.
    always_comb begin
        if (sel_ula_i == ALU_MUL) begin
            alu_res = prod_w[W-1:0];
            alu_ovf = |prod_w[2*W-1:W];
        end else begin
            alu_res = sum_w[W-1:0];
            alu_ovf = sum_w[W];
        end
    end

    // Next-state for registers; LX marks the LOAD step, which also clears RH
    // and the overflow flag for the new evaluation.
    always_comb begin
        rx_d  = rx_q;
        rs_d  = rs_q;
        rh_d  = rh_q;
        ovf_d = ovf_q;
        if (lx_i) begin
            rx_d = x_i;
        end
        if (ls_i) begin
            rs_d = (m0_i == M0_ALU) ? alu_res : a_i;
        end
        if (lx_i) begin
            rh_d = '0;
        end else if (lh_i && (m2_i == M2_ALU)) begin
            rh_d = alu_res;
        end
        if (lx_i) begin
            ovf_d = 1'b0;
        end else if (ls_i && (m0_i == M0_ALU)) begin
            ovf_d = ovf_q | alu_ovf;
        end
    end

    // Register update with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_q  <= '0;
            rs_q  <= '0;
            rh_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            rx_q  <= rx_d;
            rs_q  <= rs_d;
            rh_q  <= rh_d;
            ovf_q <= ovf_d;
        end
    end

    assign rh_o  = rh_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/poly_eval.sv
// Quadratic evaluator A*X^2 + B*X + C in Horner form, started by a level
// Start handshake. Optional build macro POLY_EVAL_DBG_EN exposes the FSM
// state on dbg_state.
//
// state | meaning
// IDLE  | waiting for Start
// LOAD  | RX<=X, RS<=A, RH and Overflow cleared
// MUL1  | RS<=RS*RX
// ADD1  | RS<=RS+B
// MUL2  | RS<=RS*RX
// ADD2  | RS<=RS+C, RH<=sum
// DONE  | finished=1, wait for Start to drop
module poly_eval
    import poly_eval_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int XW = XW_DEF
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [XW-1:0] X,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    input  logic [W-1:0]  C,
    output logic [W-1:0]  Resultado,
    output logic          Overflow,
`ifdef POLY_EVAL_DBG_EN
    output logic [2:0]    dbg_state,
`endif
    output logic          finished
);

    state_e     state_q, state_d;
    logic       lx, ls, lh, sel_ula;
    logic [1:0] m0, m1, m2;

    // State register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d  = state_q;
        lx       = 1'b0;
        ls       = 1'b0;
        lh       = 1'b0;
        sel_ula  = ALU_ADD;
        m0       = M0_A;
        m1       = M1_X;
        m2       = M2_HOLD;
        finished = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_LOAD;
            end
            S_LOAD: begin
                lx      = 1'b1;
                ls      = 1'b1;
                lh      = 1'b1;
                m0      = M0_A;
                state_d = S_MUL1;
            end
            S_MUL1: begin
                ls      = 1'b1;
                sel_ula = ALU_MUL;
                m0      = M0_ALU;
                m1      = M1_X;
                state_d = S_ADD1;
            end
            S_ADD1: begin
                ls      = 1'b1;
                sel_ula = ALU_ADD;
                m0      = M0_ALU;
                m1      = M1_B;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                ls      = 1'b1;
                sel_ula = ALU_MUL;
                m0      = M0_ALU;
                m1      = M1_X;
                state_d = S_ADD2;
            end
            S_ADD2: begin
                ls      = 1'b1;
                lh      = 1'b1;
                sel_ula = ALU_ADD;
                m0      = M0_ALU;
                m1      = M1_C;
                m2      = M2_ALU;
                state_d = S_DONE;
            end
            S_DONE: begin
                finished = 1'b1;
                if (!Start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    poly_eval_datapath #(
        .W  (W),
        .XW (XW)
    ) u_datapath (
        .clk_i     (clk),
        .rst_i     (Reset),
        .lx_i      (lx),
        .ls_i      (ls),
        .lh_i      (lh),
        .sel_ula_i (sel_ula),
        .m0_i      (m0),
        .m1_i      (m1),
        .m2_i      (m2),
        .x_i       (X),
        .a_i       (A),
        .b_i       (B),
        .c_i       (C),
        .rh_o      (Resultado),
        .ovf_o     (Overflow)
    );

`ifdef POLY_EVAL_DBG_EN
    assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_poly_eval.sv
// Directed-vector bench for poly_eval (default and POLY_EVAL_DBG_EN builds).
module tb_poly_eval;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [7:0]  X;
    logic [15:0] A, B, C;
    logic [15:0] Resultado;
    logic        Overflow;
    logic        finished;
`ifdef POLY_EVAL_DBG_EN
    logic [2:0]  dbg_state;
`endif

    int checks   = 0;
    int failures = 0;

    poly_eval dut (
        .clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .X         (X),
        .A         (A),
        .B         (B),
        .C         (C),
        .Resultado (Resultado),
        .Overflow  (Overflow),
`ifdef POLY_EVAL_DBG_EN
        .dbg_state (dbg_state),
`endif
        .finished  (finished)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Raise Start with the given operands and count edges until finished.
    task automatic run_eval(input string tag, input logic [7:0] x, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] c,
                            input logic [15:0] exp_res, input logic exp_ovf);
        int lat;
        @(negedge clk);
        X = x; A = a; B = b; C = c;
        Start = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (finished) break;
        end
        check({tag, "_latency"}, lat, 6);
        check({tag, "_res"}, Resultado, exp_res);
        check({tag, "_ovf"}, Overflow, exp_ovf);
    endtask

    task automatic drop_start(input string tag, input logic [15:0] exp_res);
        @(negedge clk);
        Start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_fin_low"}, finished, 0);
        check({tag, "_res_hold"}, Resultado, exp_res);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0;
        X = '0; A = '0; B = '0; C = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", Resultado, 0);
        check("rst_ovf", Overflow, 0);
        check("rst_fin", finished, 0);
`ifdef POLY_EVAL_DBG_EN
        check("rst_dbg", dbg_state, 0);
`endif
        @(negedge clk);
        Reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_fin", finished, 0);

        // 3*4 + 4*2 + 5 = 25
        run_eval("basic", 8'd2, 16'd3, 16'd4, 16'd5, 16'h0019, 1'b0);
`ifdef POLY_EVAL_DBG_EN
        check("done_dbg", dbg_state, 6);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("hold_fin", finished, 1);
        check("hold_res", Resultado, 16'h0019);
        drop_start("basic", 16'h0019);

        run_eval("zerox", 8'd0, 16'hFFFF, 16'd7, 16'd9, 16'h0009, 1'b0);
        drop_start("zerox", 16'h0009);

        // 0x100*0xFF = 0xFF00; 0xFF00*0xFF = 0xFE0100 -> low 16 bits 0x0100
        run_eval("ovf", 8'hFF, 16'h0100, 16'd0, 16'd0, 16'h0100, 1'b1);
        drop_start("ovf", 16'h0100);

        // Restart after an overflowing run: flag must be cleared by LOAD
        run_eval("restart", 8'd2, 16'd3, 16'd4, 16'd5, 16'h0019, 1'b0);
        drop_start("restart", 16'h0019);

        // 0xFFFF*1 + 1 carries out
        run_eval("carry", 8'd1, 16'hFFFF, 16'd1, 16'd0, 16'h0000, 1'b1);
        drop_start("carry", 16'h0000);

        // Reset during MUL2: MUL1 of 0xFFFF*0xFF already set Overflow
        @(negedge clk);
        X = 8'hFF; A = 16'hFFFF; B = 16'd0; C = 16'd0;
        Start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_ovf_pre", Overflow, 1);
        check("mid_fin_pre", finished, 0);
`ifdef POLY_EVAL_DBG_EN
        check("mid_dbg_mul2", dbg_state, 4);
`endif
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_ovf", Overflow, 0);
        check("mid_rst_res", Resultado, 0);
        check("mid_rst_fin", finished, 0);
        @(negedge clk);
        Start = 1'b0;
        Reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_fin", finished, 0);
        check("post_rst_res", Resultado, 0);
        check("post_rst_ovf", Overflow, 0);

        run_eval("recover", 8'd2, 16'd3, 16'd4, 16'd5, 16'h0019, 1'b0);
        // Asynchronous reset while parked in DONE with a nonzero result
        #3;
        Reset = 1'b1;
        #1;
        check("done_rst_res", Resultado, 0);
        check("done_rst_fin", finished, 0);
        @(negedge clk);
        Reset = 1'b0;
        Start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
